// File: rtl/note_seq_pkg.sv
// Shared types and widths for the song-level note sequencer.
package note_seq_pkg;

  localparam int unsigned note_w = 3;
  localparam int unsigned gap_w  = 8;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_issue = 2'd1,
    st_gap   = 2'd2,
    st_done  = 2'd3
  } state_t;

endpackage : note_seq_pkg

// File: rtl/note_sequencer_if.sv
// Valid/ready play-note channel between the sequencer and the multi-note player.
interface note_sequencer_if;
  import note_seq_pkg::*;

  logic              val;
  logic              rdy;
  logic [note_w-1:0] num;

  modport master (output val, output num, input rdy);
  modport slave  (input val, input num, output rdy);

endinterface : note_sequencer_if

// File: rtl/note_seq_table.sv
// Song table: register file with one synchronous write port and one combinational read port.
module note_seq_table
  import note_seq_pkg::*;
#(
  parameter int unsigned p_nentries = 16,
  localparam int unsigned a_w = (p_nentries > 1) ? $clog2(p_nentries) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [a_w-1:0]    wr_addr,
  input  logic [note_w-1:0] wr_data,
  input  logic [a_w-1:0]    rd_addr,
  output logic [note_w-1:0] rd_data
);

  logic [note_w-1:0] mem [p_nentries];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(p_nentries); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : note_seq_table

// File: rtl/note_sequencer.sv
// Song controller: plays table entries over the play-note channel with optional gap and looping.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned p_nentries = 16,
  localparam int unsigned a_w = (p_nentries > 1) ? $clog2(p_nentries) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [a_w-1:0]    wr_addr,
  input  logic [note_w-1:0] wr_data,
  input  logic [a_w-1:0]    song_last,
  input  logic [gap_w-1:0]  gap_cycles,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic [a_w-1:0]    cur_idx,
  output logic              done,
  note_sequencer_if.master  play_note
);

  state_t            state_q, state_d;
  logic [a_w-1:0]    idx_q, idx_d;
  logic [gap_w-1:0]  cnt_q, cnt_d;
  logic [a_w-1:0]    last_q, last_d;
  logic [gap_w-1:0]  gap_q, gap_d;
  logic              loop_q, loop_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              val_q, val_d;
  logic [note_w-1:0] num_q, num_d;
  logic [a_w-1:0]    cur_idx_q, cur_idx_d;

  logic              wr_fire;
  logic              fire;
  logic [note_w-1:0] tbl_rd;
  logic [note_w-1:0] rd_note;

  // Table is frozen while busy so the presented note cannot change under val.
  assign wr_fire = wr_en && (state_q == st_idle);
  assign fire    = val_q && play_note.rdy;

  note_seq_table #(.p_nentries(p_nentries)) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_d),
    .rd_data (tbl_rd)
  );

  // Forward a same-edge write so a start coinciding with a write sees the new note.
  assign rd_note = (wr_fire && (wr_addr == idx_d)) ? wr_data : tbl_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= st_idle;
      idx_q     <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      gap_q     <= '0;
      loop_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      val_q     <= 1'b0;
      num_q     <= '0;
      cur_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
      loop_q    <= loop_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      val_q     <= val_d;
      num_q     <= num_d;
      cur_idx_q <= cur_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gap_d   = gap_q;
    loop_d  = loop_q;

    unique case (state_q)
      st_idle: begin
        if (start && !stop) begin
          last_d  = song_last;
          gap_d   = gap_cycles;
          loop_d  = loop;
          idx_d   = '0;
          state_d = st_issue;
        end
      end
      st_issue: begin
        if (stop) begin
          state_d = st_idle;
        end else if (fire) begin
          if ((idx_q == last_q) && !loop_q) begin
            state_d = st_done;
          end else begin
            idx_d = (idx_q == last_q) ? '0 : idx_q + a_w'(1);
            if (gap_q != '0) begin
              cnt_d   = gap_q;
              state_d = st_gap;
            end
          end
        end
      end
      st_gap: begin
        cnt_d = cnt_q - gap_w'(1);
        if (stop) begin
          state_d = st_idle;
        end else if (cnt_q == gap_w'(1)) begin
          state_d = st_issue;
        end
      end
      st_done: begin
        state_d = st_idle;
      end
      default: begin
        state_d = st_idle;
      end
    endcase

    busy_d    = (state_d != st_idle);
    done_d    = (state_d == st_done);
    val_d     = (state_d == st_issue);
    num_d     = val_d ? rd_note : '0;
    cur_idx_d = val_d ? idx_d : cur_idx_q;
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cur_idx       = cur_idx_q;
  assign play_note.val = val_q;
  assign play_note.num = num_q;

endmodule : note_sequencer

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: playback, back-pressure, gaps, looping, stop and reset.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int unsigned n_ent = 16;
  localparam int unsigned a_w   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [a_w-1:0]    wr_addr;
  logic [note_w-1:0] wr_data;
  logic [a_w-1:0]    song_last;
  logic [gap_w-1:0]  gap_cycles;
  logic              loop;
  logic              start;
  logic              stop;
  logic              busy;
  logic [a_w-1:0]    cur_idx;
  logic              done;

  int total = 0;
  int bad   = 0;

  note_sequencer_if pn ();

  note_sequencer #(.p_nentries(n_ent)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .song_last  (song_last),
    .gap_cycles (gap_cycles),
    .loop       (loop),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .cur_idx    (cur_idx),
    .done       (done),
    .play_note  (pn.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks val/num/busy/done together for the current cycle.
  task automatic chk_out(input string tag, input logic v, input logic [2:0] n,
                         input logic b, input logic d);
    chk({tag, ".val"},  32'(pn.val), 32'(v));
    chk({tag, ".num"},  32'(pn.num), 32'(n));
    chk({tag, ".busy"}, 32'(busy),   32'(b));
    chk({tag, ".done"}, 32'(done),   32'(d));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    song_last = '0; gap_cycles = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    pn.rdy = 1'b1;
    tick(); tick();
    chk_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
    chk("reset.cur_idx", 32'(cur_idx), 32'd0);
    rst = 1'b0;

    // Program table [3,5,1]
    wr_en = 1'b1;
    wr_addr = 4'd0; wr_data = 3'd3; tick();
    wr_addr = 4'd1; wr_data = 3'd5; tick();
    wr_addr = 4'd2; wr_data = 3'd1; tick();
    wr_en = 1'b0;

    // Test 1: back-to-back playback
    song_last = 4'd2; gap_cycles = 8'd0; loop = 1'b0; pn.rdy = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t1.n0", 1'b1, 3'd3, 1'b1, 1'b0);
    chk("t1.n0.idx", 32'(cur_idx), 32'd0);
    tick(); chk_out("t1.n1", 1'b1, 3'd5, 1'b1, 1'b0);
    tick(); chk_out("t1.n2", 1'b1, 3'd1, 1'b1, 1'b0);
    chk("t1.n2.idx", 32'(cur_idx), 32'd2);
    tick(); chk_out("t1.done", 1'b0, 3'd0, 1'b1, 1'b1);
    tick(); chk_out("t1.idle", 1'b0, 3'd0, 1'b0, 1'b0);
    chk("t1.idle.idx", 32'(cur_idx), 32'd2);

    // Test 2: back-pressure holds the first note
    pn.rdy = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("t2.hold%0d", i), 1'b1, 3'd3, 1'b1, 1'b0);
      chk($sformatf("t2.hold%0d.idx", i), 32'(cur_idx), 32'd0);
      tick();
    end
    chk_out("t2.c6", 1'b1, 3'd3, 1'b1, 1'b0);
    pn.rdy = 1'b1;
    tick(); chk_out("t2.n1", 1'b1, 3'd5, 1'b1, 1'b0);
    tick(); chk_out("t2.n2", 1'b1, 3'd1, 1'b1, 1'b0);
    tick(); chk_out("t2.done", 1'b0, 3'd0, 1'b1, 1'b1);
    tick(); chk_out("t2.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // Test 3: four-cycle gap between notes
    gap_cycles = 8'd4;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t3.n0", 1'b1, 3'd3, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("t3.gapA%0d", i), 1'b0, 3'd0, 1'b1, 1'b0);
      tick();
    end
    chk_out("t3.n1", 1'b1, 3'd5, 1'b1, 1'b0);
    chk("t3.n1.idx", 32'(cur_idx), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("t3.gapB%0d", i), 1'b0, 3'd0, 1'b1, 1'b0);
      chk($sformatf("t3.gapB%0d.idx", i), 32'(cur_idx), 32'd1);
      tick();
    end
    chk_out("t3.n2", 1'b1, 3'd1, 1'b1, 1'b0);
    tick(); chk_out("t3.done", 1'b0, 3'd0, 1'b1, 1'b1);
    tick(); chk_out("t3.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    // Test 4: looping over two entries, then stop
    gap_cycles = 8'd0; loop = 1'b1; song_last = 4'd1;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t4.n0", 1'b1, 3'd3, 1'b1, 1'b0);
    tick(); chk_out("t4.n1", 1'b1, 3'd5, 1'b1, 1'b0);
    tick(); chk_out("t4.n2", 1'b1, 3'd3, 1'b1, 1'b0);
    chk("t4.n2.idx", 32'(cur_idx), 32'd0);
    tick(); chk_out("t4.n3", 1'b1, 3'd5, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("t4.stop", 1'b0, 3'd0, 1'b0, 1'b0);
    chk("t4.stop.idx", 32'(cur_idx), 32'd1);
    tick(); chk_out("t4.after", 1'b0, 3'd0, 1'b0, 1'b0);

    // start with stop in IDLE stays idle
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk_out("t4.startstop", 1'b0, 3'd0, 1'b0, 1'b0);

    // Test 5: writes and start ignored while busy
    loop = 1'b0; song_last = 4'd2;
    start = 1'b1; tick();
    chk_out("t5.n0", 1'b1, 3'd3, 1'b1, 1'b0);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 3'd7;
    tick(); wr_en = 1'b0; start = 1'b0;
    chk_out("t5.n1", 1'b1, 3'd5, 1'b1, 1'b0);
    tick(); chk_out("t5.n2", 1'b1, 3'd1, 1'b1, 1'b0);
    tick(); chk_out("t5.done", 1'b0, 3'd0, 1'b1, 1'b1);
    tick(); chk_out("t5.idle", 1'b0, 3'd0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t5.r0", 1'b1, 3'd3, 1'b1, 1'b0);
    tick(); chk_out("t5.r1", 1'b1, 3'd5, 1'b1, 1'b0);
    tick(); chk_out("t5.r2", 1'b1, 3'd1, 1'b1, 1'b0);
    tick(); chk_out("t5.rdone", 1'b0, 3'd0, 1'b1, 1'b1);
    tick();

    // Test 6: reset mid-ISSUE clears state and table
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_out("t6.pre", 1'b1, 3'd5, 1'b1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_out("t6.rst", 1'b0, 3'd0, 1'b0, 1'b0);
    chk("t6.rst.idx", 32'(cur_idx), 32'd0);
    song_last = 4'd2; gap_cycles = 8'd0; loop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("t6.n0", 1'b1, 3'd0, 1'b1, 1'b0);
    tick(); chk_out("t6.n1", 1'b1, 3'd0, 1'b1, 1'b0);
    chk("t6.n1.idx", 32'(cur_idx), 32'd1);
    tick(); chk_out("t6.n2", 1'b1, 3'd0, 1'b1, 1'b0);
    chk("t6.n2.idx", 32'(cur_idx), 32'd2);
    tick(); chk_out("t6.done", 1'b0, 3'd0, 1'b1, 1'b1);
    tick(); chk_out("t6.idle", 1'b0, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_note_sequencer
